// File: rtl/bk_pkg.sv
// -----------------------------------------------------------------------------
// bk_pkg
// Shared definitions for the Brent-Kung operand recovery path.
//   BK_WIDTH      : addend width (sum is BK_WIDTH+1 bits)
//   BK_DIGIT_W    : bits resolved per clock by the digit-serial subtractor
//   bk_state_e    : control FSM states
//   bk_num_digits : number of digit steps needed for one operand
// -----------------------------------------------------------------------------
package bk_pkg;

  localparam int BK_WIDTH   = 12;
  localparam int BK_DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bk_state_e;

  // Number of DIGIT_W-wide steps that cover a WIDTH-bit operand.
  function automatic int bk_num_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

endpackage : bk_pkg

// File: rtl/bk_digit_sub.sv
// -----------------------------------------------------------------------------
// bk_digit_sub
// Purely combinational DIGIT_W-bit ripple subtractor: diff = a - b - borrow_in.
//   a          : minuend digit
//   b          : subtrahend digit
//   borrow_in  : borrow from the previous (less significant) digit
//   diff       : difference digit
//   borrow_out : borrow into the next (more significant) digit
// -----------------------------------------------------------------------------
module bk_digit_sub #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] diff,
  output logic               borrow_out
);

  logic bw_s;

  // Bit-by-bit ripple of the borrow chain through the digit.
  always_comb begin
    diff = '0;
    bw_s = borrow_in;
    for (int i = 0; i < DIGIT_W; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw_s;
      // Borrow out when a < b + borrow at this bit position.
      bw_s    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw_s);
    end
    borrow_out = bw_s;
  end

endmodule : bk_digit_sub

// File: rtl/bk_operand_recover.sv
// -----------------------------------------------------------------------------
// bk_operand_recover
// Digit-serial inverse of the Brent-Kung adder: recovers B = SUM - A and flags
// sums that no WIDTH-bit B could have produced.
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   in_valid   : request valid          in_ready  : block idle, can accept
//   in_sum     : WIDTH+1-bit adder sum  in_a      : known WIDTH-bit addend
//   out_valid  : result valid           out_ready : consumer accepts result
//   out_b      : (in_sum - in_a) mod 2^WIDTH
//   out_err    : in_sum < in_a or in_sum - in_a >= 2^WIDTH
// -----------------------------------------------------------------------------
module bk_operand_recover
  import bk_pkg::*;
#(
  parameter int WIDTH   = BK_WIDTH,
  parameter int DIGIT_W = BK_DIGIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err
);

  localparam int N     = bk_num_digits(WIDTH, DIGIT_W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_cfg
      $error("bk_operand_recover: WIDTH must be a multiple of DIGIT_W");
    end
  endgenerate

  bk_state_e          state_r;
  logic [WIDTH:0]     sum_r;
  logic [WIDTH-1:0]   a_r;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [DIGIT_W-1:0] diff_s;
  logic               borrow_s;
  logic               top_bit_s;
  logic               t_s;
  logic               t_borrow_s;

  bk_digit_sub #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_sub (
    .a          (sum_r[DIGIT_W-1:0]),
    .b          (a_r[DIGIT_W-1:0]),
    .borrow_in  (borrow_r),
    .diff       (diff_s),
    .borrow_out (borrow_s)
  );

  // Sum bit WIDTH minus the final borrow; after N-1 shifts the original top
  // sum bit sits just above the digit currently being processed.
  always_comb begin
    top_bit_s  = sum_r[DIGIT_W];
    t_s        = top_bit_s ^ borrow_s;
    t_borrow_s = ~top_bit_s & borrow_s;
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  // Control FSM with operand shift registers, borrow flop and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      sum_r    <= '0;
      a_r      <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      out_b    <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sum_r    <= in_sum;
            a_r      <= in_a;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          // Difference digits enter from the MSB side so the first digit
          // lands in the LSBs after N shifts.
          out_b    <= {diff_s, out_b[WIDTH-1:DIGIT_W]};
          borrow_r <= borrow_s;
          sum_r    <= sum_r >> DIGIT_W;
          a_r      <= a_r >> DIGIT_W;
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            out_err <= t_borrow_s | t_s;
            state_r <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule : bk_operand_recover

// File: tb/tb_bk_operand_recover.sv
// -----------------------------------------------------------------------------
// tb_bk_operand_recover
// Directed scoreboard bench for bk_operand_recover. The driver pushes the
// hand-computed result when a request is accepted; the monitor pops and
// compares whenever a result handshake is presented.
// -----------------------------------------------------------------------------
module tb_bk_operand_recover;

  typedef struct packed {
    logic [11:0] b;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_sum;
  logic [11:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_b;
  logic        out_err;

  exp_t exp_q[$];
  int   total;
  int   bad;

  bk_operand_recover dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result monitor: compares each presented handshake against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected got b=%h err=%b want none", out_b, out_err);
      end else begin
        e = exp_q.pop_front();
        if (out_b !== e.b || out_err !== e.err) begin
          bad++;
          $display("FAIL result got b=%h err=%b want b=%h err=%b", out_b, out_err, e.b, e.err);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Caller is at #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [12:0] s, input logic [11:0] a,
                      input logic [11:0] eb, input logic ee);
    int n;
    exp_t e;
    in_sum   = s;
    in_a     = a;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end
    @(posedge clk);
    e.b   = eb;
    e.err = ee;
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = 13'h0000;
    in_a      = 12'h000;
    out_ready = 1'b1;
    total     = 0;
    bad       = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready",  {11'h000, in_ready},  12'h001);
    check1("rst_out_valid", {11'h000, out_valid}, 12'h000);
    check1("rst_out_b",     out_b,                12'h000);
    check1("rst_out_err",   {11'h000, out_err},   12'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic subtraction plus latency from acceptance.
    send(13'h0005, 12'h003, 12'h002, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check1("latency", 12'(n), 12'd6);
    drain();

    send(13'h1FFE, 12'hFFF, 12'hFFF, 1'b0); drain();
    send(13'h0002, 12'h003, 12'hFFF, 1'b1); drain();
    send(13'h1800, 12'h100, 12'h700, 1'b1); drain();
    send(13'h1000, 12'h001, 12'hFFF, 1'b0); drain();
    send(13'h1000, 12'h000, 12'h000, 1'b1); drain();
    send(13'h0000, 12'h000, 12'h000, 1'b0); drain();
    send(13'h0A5A, 12'h5A5, 12'h4B5, 1'b0); drain();

    // Backpressure with a new request waiting on in_valid.
    out_ready = 1'b0;
    send(13'h00A0, 12'h00F, 12'h091, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_sum   = 13'h0010;
    in_a     = 12'h020;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check1("bp_out_valid", {11'h000, out_valid}, 12'h001);
      check1("bp_out_b",     out_b,                12'h091);
      check1("bp_out_err",   {11'h000, out_err},   12'h000);
      check1("bp_in_ready",  {11'h000, in_ready},  12'h000);
    end
    out_ready = 1'b1;
    send(13'h0010, 12'h020, 12'hFF0, 1'b1);
    drain();

    // Reset during the third BUSY cycle aborts the transaction.
    send(13'h05A5, 12'h123, 12'h482, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check1("abort_out_valid", {11'h000, out_valid}, 12'h000);
    check1("abort_out_b",     out_b,                12'h000);
    check1("abort_out_err",   {11'h000, out_err},   12'h000);
    check1("abort_in_ready",  {11'h000, in_ready},  12'h001);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(13'h0100, 12'h0FF, 12'h001, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bk_operand_recover
